// File: rtl/serial_mod_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_mod_checker_if                                         |
// | Purpose  : Digit stream and result bundle for serial_mod_checker.        |
// |   master : digit producer (drives in_*, observes out_*)                  |
// |   slave  : checker (consumes in_*, drives out_*)                         |
// | Signals  : in_valid, in_start, in_data[BITS_PER_CYCLE]                   |
// |            out_valid, out_divisible, out_remainder[RW],                  |
// |            out_count[COUNT_W]                                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface serial_mod_checker_if #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int RW             = 3,
  parameter int COUNT_W        = 8
);
  logic                      in_valid;
  logic                      in_start;
  logic [BITS_PER_CYCLE-1:0] in_data;
  logic                      out_valid;
  logic                      out_divisible;
  logic [RW-1:0]             out_remainder;
  logic [COUNT_W-1:0]        out_count;

  modport master (
    output in_valid, in_start, in_data,
    input  out_valid, out_divisible, out_remainder, out_count
  );

  modport slave (
    input  in_valid, in_start, in_data,
    output out_valid, out_divisible, out_remainder, out_count
  );
endinterface
`default_nettype wire

// File: rtl/serial_mod_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_mod_checker                                            |
// | Purpose  : Serial divisibility checker. Accepts one BITS_PER_CYCLE-bit   |
// |            digit per valid cycle and keeps the running value modulo      |
// |            DIVISOR, flagging divisibility after every accepted digit.    |
// | Ports    : clk  - rising-edge clock                                      |
// |            rst  - synchronous active-high reset                          |
// |            bus  - serial_mod_checker_if.slave (in_valid, in_start,       |
// |                   in_data, out_valid, out_divisible, out_remainder,      |
// |                   out_count)                                             |
// | Options  : SERIAL_MOD_LSB_FIRST_EN - digits arrive LSB-first; adds a     |
// |            weight register tracking 2^(B*k) mod DIVISOR.                 |
// |            Default (undefined): MSB-first only.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module serial_mod_checker #(
  parameter int DIVISOR        = 5,
  parameter int BITS_PER_CYCLE = 1,
  parameter int COUNT_W        = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  serial_mod_checker_if.slave bus
);

  localparam int RW = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1;
  localparam int B  = BITS_PER_CYCLE;
  // One spare bit above RW+B so the divisor itself (up to 2^RW) and the
  // LSB-first sum (r + d*w) both fit without overflow.
  localparam int W  = RW + B + 1;

  localparam logic [W-1:0]       c_DIV     = W'(DIVISOR);
  localparam logic [COUNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] c_CNT_ONE = COUNT_W'(1);

  if (DIVISOR < 2 || DIVISOR > 65536) begin : g_bad_divisor
    $error("serial_mod_checker: DIVISOR %0d outside 2..65536", DIVISOR);
  end
  if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > 8) begin : g_bad_bits
    $error("serial_mod_checker: BITS_PER_CYCLE %0d outside 1..8", BITS_PER_CYCLE);
  end

  logic [RW-1:0]      r_rem;
  logic               r_valid;
  logic               r_div;
  logic [COUNT_W-1:0] r_count;

  logic [RW-1:0]      w_base_r;
  logic [W-1:0]       w_sum;
  logic [RW-1:0]      w_rem_next;

  // A start digit discards whatever number was in flight.
  assign w_base_r = bus.in_start ? '0 : r_rem;

`ifdef SERIAL_MOD_LSB_FIRST_EN
  // DIVISOR >= 2, so 1 mod DIVISOR is simply 1.
  localparam logic [RW-1:0] c_ONE = RW'(1);

  logic [RW-1:0] r_w;
  logic [RW-1:0] w_base_w;
  logic [W-1:0]  w_wshift;
  logic [RW-1:0] w_w_next;

  assign w_base_w = bus.in_start ? c_ONE : r_w;
  assign w_sum    = W'(w_base_r) + (W'(bus.in_data) * W'(w_base_w));
  assign w_wshift = {1'b0, w_base_w, {B{1'b0}}};
  assign w_w_next = RW'(w_wshift % c_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w <= c_ONE;
    end else if (bus.in_valid) begin
      r_w <= w_w_next;
    end
  end
`else
  // Concatenation is base * 2^B + digit without any truncation.
  assign w_sum = {1'b0, w_base_r, bus.in_data};
`endif

  assign w_rem_next = RW'(w_sum % c_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_div   <= 1'b0;
      r_count <= '0;
    end else if (bus.in_valid) begin
      r_rem   <= w_rem_next;
      r_valid <= 1'b1;
      r_div   <= (w_rem_next == '0);
      // After reset the count is 0, so a first digit without in_start
      // still reads 1, matching an explicit start.
      if (bus.in_start) begin
        r_count <= c_CNT_ONE;
      end else if (r_count != c_CNT_MAX) begin
        r_count <= r_count + c_CNT_ONE;
      end
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.out_divisible = r_div;
  assign bus.out_remainder = r_rem;
  assign bus.out_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_mod_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_serial_mod_checker                                         |
// | Purpose  : Scoreboard bench for serial_mod_checker. Three instances:     |
// |            D=5/B=1, D=3/B=2 and D=5/B=1 with a 2-bit counter. Each step  |
// |            queues the expected outputs; per-instance monitors compare    |
// |            on the falling edge.                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_serial_mod_checker;

  typedef struct {
    logic        v;
    logic        d;
    logic [15:0] rem;
    logic [7:0]  cnt;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nstep  = 0;

  exp_t q5[$];
  exp_t q3[$];
  exp_t qc[$];
  exp_t e5, e3, ec;

  serial_mod_checker_if #(.BITS_PER_CYCLE(1), .RW(3), .COUNT_W(8)) if5 ();
  serial_mod_checker_if #(.BITS_PER_CYCLE(2), .RW(2), .COUNT_W(8)) if3 ();
  serial_mod_checker_if #(.BITS_PER_CYCLE(1), .RW(3), .COUNT_W(2)) ifc ();

  serial_mod_checker #(.DIVISOR(5), .BITS_PER_CYCLE(1), .COUNT_W(8)) dut5 (
    .clk(clk), .rst(rst), .bus(if5));
  serial_mod_checker #(.DIVISOR(3), .BITS_PER_CYCLE(2), .COUNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .bus(if3));
  serial_mod_checker #(.DIVISOR(5), .BITS_PER_CYCLE(1), .COUNT_W(2)) dutc (
    .clk(clk), .rst(rst), .bus(ifc));

  function automatic void check(input string name, input logic av, input logic ad,
                                input logic [15:0] arem, input logic [7:0] acnt,
                                input exp_t e);
    checks++;
    if (av !== e.v || ad !== e.d || arem !== e.rem || acnt !== e.cnt) begin
      errors++;
      $display("FAIL %s step %0d: got valid=%0b div=%0b rem=%0d cnt=%0d, expected valid=%0b div=%0b rem=%0d cnt=%0d",
               name, e.idx, av, ad, arem, acnt, e.v, e.d, e.rem, e.cnt);
    end
  endfunction

  always @(negedge clk) begin
    if (q5.size() > 0) begin
      e5 = q5.pop_front();
      check("d5", if5.out_valid, if5.out_divisible, 16'(if5.out_remainder),
            8'(if5.out_count), e5);
    end
  end

  always @(negedge clk) begin
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      check("d3", if3.out_valid, if3.out_divisible, 16'(if3.out_remainder),
            8'(if3.out_count), e3);
    end
  end

  always @(negedge clk) begin
    if (qc.size() > 0) begin
      ec = qc.pop_front();
      check("cnt2", ifc.out_valid, ifc.out_divisible, 16'(ifc.out_remainder),
            8'(ifc.out_count), ec);
    end
  end

  // Drive one cycle of stimulus on instance id and queue its expected outputs.
  task automatic step(input int id, input logic r, input logic v, input logic s,
                      input logic [1:0] data, input logic ev, input logic ed,
                      input int erem, input int ecnt);
    exp_t e;
    @(negedge clk);
    #1;
    rst          = r;
    if5.in_valid = (id == 0) && v;
    if3.in_valid = (id == 1) && v;
    ifc.in_valid = (id == 2) && v;
    if5.in_start = s;
    if3.in_start = s;
    ifc.in_start = s;
    if5.in_data  = data[0];
    if3.in_data  = data;
    ifc.in_data  = data[0];
    e.v   = ev;
    e.d   = ed;
    e.rem = 16'(erem);
    e.cnt = 8'(ecnt);
    e.idx = nstep;
    nstep++;
    case (id)
      0:       q5.push_back(e);
      1:       q3.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if5.in_valid = 1'b0; if5.in_start = 1'b0; if5.in_data = '0;
    if3.in_valid = 1'b0; if3.in_start = 1'b0; if3.in_data = '0;
    ifc.in_valid = 1'b0; ifc.in_start = 1'b0; ifc.in_data = '0;

    // Reset state on every instance.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(2, 1, 0, 0, 0, 0, 0, 0, 0);

`ifdef SERIAL_MOD_LSB_FIRST_EN
    // LSB-first 0,1,0,1 = 10: weights 1,2,4,3 -> rem 0,2,2,0.
    step(0, 0, 1, 1, 0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 1, 1, 0, 2, 2);
    step(0, 0, 1, 0, 0, 1, 0, 2, 3);
    step(0, 0, 1, 0, 1, 1, 1, 0, 4);
`else
    // MSB-first 1,0,1,0 = 10: rem 1,2,0,0.
    step(0, 0, 1, 1, 1, 1, 0, 1, 1);
    step(0, 0, 1, 0, 0, 1, 0, 2, 2);
    step(0, 0, 1, 0, 1, 1, 1, 0, 3);
    step(0, 0, 1, 0, 0, 1, 1, 0, 4);
`endif

    // 1,1,<gap x2, one with stray in_start>,0; outputs hold during the gap.
    step(0, 0, 1, 1, 1, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1, 0, 3, 2);
    step(0, 0, 0, 1, 1, 1, 0, 3, 2);
    step(0, 0, 0, 0, 0, 1, 0, 3, 2);
`ifdef SERIAL_MOD_LSB_FIRST_EN
    step(0, 0, 1, 0, 0, 1, 0, 3, 3);
`else
    step(0, 0, 1, 0, 0, 1, 0, 1, 3);
`endif

    // Reset mid-number (with a valid digit present), then continue without start,
    // then restart mid-number with a zero digit.
    step(0, 0, 1, 1, 1, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1, 0, 3, 2);
    step(0, 1, 1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 1, 0, 1, 1);
    step(0, 0, 1, 1, 0, 1, 1, 0, 1);

    // D=3, B=2: digits 2,1 = 9 -> rem 2,0; then new number with digit 1.
    step(1, 0, 1, 1, 2, 1, 0, 2, 1);
    step(1, 0, 1, 0, 1, 1, 1, 0, 2);
    step(1, 0, 1, 1, 1, 1, 0, 1, 1);

    // 2-bit counter saturates at 3.
    step(2, 0, 1, 1, 0, 1, 1, 0, 1);
    step(2, 0, 1, 0, 0, 1, 1, 0, 2);
    step(2, 0, 1, 0, 0, 1, 1, 0, 3);
    step(2, 0, 1, 0, 0, 1, 1, 0, 3);
    step(2, 0, 1, 0, 0, 1, 1, 0, 3);
    step(2, 0, 1, 0, 0, 1, 1, 0, 3);

    @(negedge clk);
    #1;
    if5.in_valid = 1'b0;
    if3.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q5.size() + q3.size() + qc.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0",
               q5.size() + q3.size() + qc.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
